exu_cal: RTL and testbench

//  - Execution-unit calculation centre, directly downstream of the ALU front end.
//  - Consumes the packed calculation op-bundle (op one-hots plus two 33-bit extended operands) and returns a 32-bit result.
//  - Returns a ready handshake.
//  - ADD/SUB/XOR/CMP complete in the request cycle; SLL/SRL/SRA run on an iterative shifter FSM.

---
 rtl/exu_cal_pkg.sv | 55 +++++
 rtl/exu_cal_shifter.sv | 53 +++++
 rtl/exu_cal.sv | 151 +++++++++++++++
 tb/tb_exu_cal.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/exu_cal_pkg.sv
// ============================================================================
// Module : exu_cal_pkg
// Brief  : Op-bundle field map, FSM encodings and shift helper for exu_cal.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package exu_cal_pkg;

  // Op-bundle layout, MSB first: {ADD,SUB,SLL,SRL,SRA,XOR,CMP, OPN1[32:0], OPN2[32:0]}
  localparam int CIRNO_CAL_OPN2_LSB = 0;
  localparam int CIRNO_CAL_OPN2_MSB = 32;
  localparam int CIRNO_CAL_OPN1_LSB = 33;
  localparam int CIRNO_CAL_OPN1_MSB = 65;
  localparam int CIRNO_CAL_CMP      = 66;
  localparam int CIRNO_CAL_XOR      = 67;
  localparam int CIRNO_CAL_SRA      = 68;
  localparam int CIRNO_CAL_SRL      = 69;
  localparam int CIRNO_CAL_SLL      = 70;
  localparam int CIRNO_CAL_SUB      = 71;
  localparam int CIRNO_CAL_ADD      = 72;
  localparam int CIRNO_CAL_OPB_SIZE = 73;

  localparam logic [1:0] CIRNO_CAL_ST_IDLE  = 2'd0;
  localparam logic [1:0] CIRNO_CAL_ST_SHIFT = 2'd1;
  localparam logic [1:0] CIRNO_CAL_ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = CIRNO_CAL_ST_IDLE,
    ST_SHIFT = CIRNO_CAL_ST_SHIFT,
    ST_DONE  = CIRNO_CAL_ST_DONE
  } cal_state_e;

  typedef enum logic [1:0] {
    SK_SLL = 2'd0,
    SK_SRL = 2'd1,
    SK_SRA = 2'd2
  } shift_kind_e;

  // 33-bit shift; SRA replicates bit 32, the others fill with zero.
  function automatic logic [32:0] cal_shift(input shift_kind_e kind,
                                            input logic [32:0] src,
                                            input logic [4:0]  amt);
    logic [32:0] r;
    case (kind)
      SK_SLL:  r = src << amt;
      SK_SRL:  r = src >> amt;
      default: r = $unsigned($signed(src) >>> amt);
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exu_cal_shifter.sv
// ============================================================================
// Module : exu_cal_shifter
// Brief  : Iterative shifter: shift register, remaining count and step logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exu_cal_shifter
  import exu_cal_pkg::*;
#(
  parameter int SHIFT_STEP = 1    // legal values 1, 2, 4, 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  shift_kind_e kind,
  input  logic [4:0]  shamt,
  input  logic [32:0] src,
  output logic        done,
  output logic [31:0] res
);

  localparam logic [4:0] c_step = 5'(SHIFT_STEP);

  logic [32:0] r_shreg;
  logic [4:0]  r_cnt;
  shift_kind_e r_kind;
  logic [4:0]  w_step;

  assign w_step = (r_cnt < c_step) ? r_cnt : c_step;
  // This step consumes everything that is left.
  assign done   = (r_cnt == w_step);
  assign res    = r_shreg[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_kind  <= SK_SLL;
    end else if (load) begin
      r_shreg <= src;
      r_cnt   <= shamt;
      r_kind  <= kind;
    end else if (en) begin
      r_shreg <= cal_shift(r_kind, r_shreg, w_step);
      r_cnt   <= r_cnt - w_step;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exu_cal.sv
// ============================================================================
// Module : exu_cal
// Brief  : Execution-unit calculation centre (ADD/SUB/XOR/CMP/SLL/SRL/SRA).
//          Define CIRNO_CAL_FAST_SHIFT_EN for single-cycle barrel shifts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exu_cal
  import exu_cal_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hs_al4cal_val,
  output logic                          hs_cal4al_rdy,
  input  logic [CIRNO_CAL_OPB_SIZE-1:0] i_cal_opb,
  output logic [31:0]                   o_cal_res,
  output logic                          o_cal_busy
);

  logic [32:0] w_opn1;
  logic [32:0] w_opn2;
  logic        w_op_add, w_op_sub, w_op_sll, w_op_srl, w_op_sra, w_op_xor, w_op_cmp;
  logic        w_shift_op;
  logic [4:0]  w_shamt;
  shift_kind_e w_kind;
  logic [32:0] w_cmp_diff;
  logic [31:0] w_arith_res;
  logic        w_rdy;
  logic [31:0] w_res;

  assign w_opn1   = i_cal_opb[CIRNO_CAL_OPN1_MSB:CIRNO_CAL_OPN1_LSB];
  assign w_opn2   = i_cal_opb[CIRNO_CAL_OPN2_MSB:CIRNO_CAL_OPN2_LSB];
  assign w_op_add = i_cal_opb[CIRNO_CAL_ADD];
  assign w_op_sub = i_cal_opb[CIRNO_CAL_SUB];
  assign w_op_sll = i_cal_opb[CIRNO_CAL_SLL];
  assign w_op_srl = i_cal_opb[CIRNO_CAL_SRL];
  assign w_op_sra = i_cal_opb[CIRNO_CAL_SRA];
  assign w_op_xor = i_cal_opb[CIRNO_CAL_XOR];
  assign w_op_cmp = i_cal_opb[CIRNO_CAL_CMP];

  assign w_shift_op = w_op_sll | w_op_srl | w_op_sra;
  assign w_shamt    = w_opn2[4:0];
  assign w_kind     = w_op_sll ? SK_SLL : (w_op_srl ? SK_SRL : SK_SRA);

  // Sign of the 33-bit difference; signedness comes from upstream extension.
  assign w_cmp_diff = w_opn1 - w_opn2;

  always_comb begin
    w_arith_res = '0;
    if (w_op_add)      w_arith_res = w_opn1[31:0] + w_opn2[31:0];
    else if (w_op_sub) w_arith_res = w_opn1[31:0] - w_opn2[31:0];
    else if (w_op_xor) w_arith_res = w_opn1[31:0] ^ w_opn2[31:0];
    else if (w_op_cmp) w_arith_res = {31'b0, w_cmp_diff[32]};
  end

`ifdef CIRNO_CAL_FAST_SHIFT_EN

  logic [32:0] w_fast_shift;

  assign w_fast_shift = cal_shift(w_kind, w_opn1, w_shamt);
  assign o_cal_busy   = 1'b0;

  always_comb begin
    w_rdy = hs_al4cal_val;
    w_res = '0;
    if (hs_al4cal_val) w_res = w_shift_op ? w_fast_shift[31:0] : w_arith_res;
  end

`else

  cal_state_e  r_state;
  cal_state_e  w_state_nxt;
  logic        w_load;
  logic        w_en;
  logic        w_sh_done;
  logic [31:0] w_sh_res;

  exu_cal_shifter #(
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .en    (w_en),
    .kind  (w_kind),
    .shamt (w_shamt),
    .src   (w_opn1),
    .done  (w_sh_done),
    .res   (w_sh_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_res       = '0;
    w_load      = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (hs_al4cal_val) begin
          if (!w_shift_op) begin
            w_rdy = 1'b1;
            w_res = w_arith_res;
          end else if (w_shamt == 5'd0) begin
            w_rdy = 1'b1;
            w_res = w_opn1[31:0];
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        // Dropping val mid-shift abandons the request.
        if (!hs_al4cal_val) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_en = 1'b1;
          if (w_sh_done) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (hs_al4cal_val) begin
          w_rdy = 1'b1;
          w_res = w_sh_res;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_cal_busy = (r_state != ST_IDLE);

`endif

  // Outputs stay quiet while reset is held, even with a request pending.
  assign hs_cal4al_rdy = w_rdy & rst_n;
  assign o_cal_res     = rst_n ? w_res : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_exu_cal.sv
// ============================================================================
// Module : tb_exu_cal
// Brief  : Randomised and directed bench for exu_cal against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exu_cal;

  localparam int STEP = 1;
  localparam int OP_ADD = 0, OP_SUB = 1, OP_SLL = 2, OP_SRL = 3,
                 OP_SRA = 4, OP_XOR = 5, OP_CMP = 6, OP_NONE = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        val = 1'b0;
  logic        rdy;
  logic [72:0] opb = '0;
  logic [31:0] res;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  exu_cal #(.SHIFT_STEP(STEP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hs_al4cal_val (val),
    .hs_cal4al_rdy (rdy),
    .i_cal_opb     (opb),
    .o_cal_res     (res),
    .o_cal_busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [72:0] pack(input int op, input logic [32:0] o1, input logic [32:0] o2);
    logic [6:0] oh;
    oh = '0;
    if (op < 7) oh[6-op] = 1'b1;
    return {oh, o1, o2};
  endfunction

  function automatic logic [31:0] model_res(input int op, input logic [32:0] o1, input logic [32:0] o2);
    logic [32:0] t;
    int sh;
    sh = int'(o2[4:0]);
    t = '0;
    case (op)
      OP_ADD: t = {1'b0, o1[31:0] + o2[31:0]};
      OP_SUB: t = {1'b0, o1[31:0] - o2[31:0]};
      OP_XOR: t = o1 ^ o2;
      OP_CMP: begin t = o1 - o2; t = {32'b0, t[32]}; end
      OP_SLL: t = o1 << sh;
      OP_SRL: t = o1 >> sh;
      OP_SRA: for (int i = 0; i < 33; i++) t[i] = (i + sh <= 32) ? o1[i+sh] : o1[32];
      default: t = '0;
    endcase
    return t[31:0];
  endfunction

  function automatic int model_lat(input int op, input logic [32:0] o2);
    int sh;
    sh = int'(o2[4:0]);
`ifdef CIRNO_CAL_FAST_SHIFT_EN
    return 0;
`else
    if (op < OP_SLL || op > OP_SRA || sh == 0) return 0;
    return (sh + STEP - 1) / STEP + 1;
`endif
  endfunction

  task automatic do_req(input int op, input logic [32:0] o1, input logic [32:0] o2, input string name);
    logic [31:0] exp;
    int lat;
    int c;
    bit got;
    exp = model_res(op, o1, o2);
    lat = model_lat(op, o2);
    @(negedge clk);
    val = 1'b1;
    opb = pack(op, o1, o2);
    c = 0;
    got = 0;
    #1;
    while (!got && c <= 40) begin
      if (rdy === 1'b1) begin
        got = 1;
      end else begin
        n_checks++;
        if (res !== 32'd0) begin
          n_errors++;
          $display("FAIL %s idle_res: got %h expected 00000000", name, res);
        end
        @(negedge clk);
        #1;
        c++;
      end
    end
    n_checks++;
    if (!got || c != lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d (rdy seen %0d) expected %0d", name, c, got, lat);
    end
    n_checks++;
    if (got && res !== exp) begin
      n_errors++;
      $display("FAIL %s result: got %h expected %h", name, res, exp);
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    val = 1'b0;
    opb = '0;
  endtask

  task automatic test_reset();
    val = 1'b1;
    opb = pack(OP_ADD, 33'h1, 33'h2);
    #3;
    n_checks++;
    if (rdy !== 1'b0 || res !== 32'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: got rdy=%b res=%h busy=%b expected 0/0/0", rdy, res, busy);
    end
    val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    do_req(OP_ADD, 33'h0_FFFFFFFF, 33'h0_00000001, "add_wrap");
    do_req(OP_SUB, 33'h0_00000000, 33'h0_00000001, "sub_wrap");
    do_req(OP_XOR, 33'h1_A5A5A5A5, 33'h0_0F0F0F0F, "xor");
    do_req(OP_CMP, 33'h1_FFFFFFFF, 33'h0_00000001, "cmp_signed");
    do_req(OP_CMP, 33'h0_FFFFFFFF, 33'h0_00000001, "cmp_unsigned");
    do_req(OP_NONE, 33'h0_12345678, 33'h0_9ABCDEF0, "no_op");
    idle_bus();
  endtask

  task automatic test_shift();
    do_req(OP_SRA, 33'h1_80000000, 33'h0_00000004, "sra4");
    do_req(OP_SLL, 33'h0_00000001, 33'h0_0000001F, "sll31");
    do_req(OP_SRL, 33'h1_DEADBEEF, 33'h0_00000000, "srl_sh0");
    do_req(OP_SRL, 33'h1_80000001, 33'h0_00000001, "srl1_bit32");
    idle_bus();
  endtask

  task automatic test_back_to_back();
    do_req(OP_SRL, 33'h0_F0000000, 33'h0_00000007, "b2b_srl");
    do_req(OP_ADD, 33'h0_00000010, 33'h0_00000020, "b2b_add");
    idle_bus();
  endtask

  task automatic test_flush();
`ifndef CIRNO_CAL_FAST_SHIFT_EN
    @(negedge clk);
    val = 1'b1;
    opb = pack(OP_SLL, 33'h0_00000003, 33'h0_00000010);
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_busy_before: got %b expected 1", busy);
    end
    val = 1'b0;
    #1;
    n_checks++;
    if (rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_rdy: got %b expected 0", rdy);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_after: got busy=%b rdy=%b expected 0/0", busy, rdy);
    end
`endif
    do_req(OP_ADD, 33'h0_7FFFFFFF, 33'h0_00000001, "flush_add");
    idle_bus();
  endtask

  task automatic test_reset_mid_shift();
`ifndef CIRNO_CAL_FAST_SHIFT_EN
    @(negedge clk);
    val = 1'b1;
    opb = pack(OP_SLL, 33'h0_00000001, 33'h0_00000014);
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rdy !== 1'b0 || busy !== 1'b0 || res !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid_shift: got rdy=%b busy=%b res=%h expected 0/0/0", rdy, busy, res);
    end
    val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    do_req(OP_SLL, 33'h0_00000001, 33'h0_00000014, "post_reset_sll");
    idle_bus();
  endtask

  task automatic test_random();
    int op;
    logic [32:0] o1, o2;
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 7));
      o1 = {1'($urandom_range(0, 1)), 32'($urandom)};
      o2 = {1'($urandom_range(0, 1)), 32'($urandom)};
      do_req(op, o1, o2, "random");
      if ($urandom_range(0, 3) == 0) idle_bus();
    end
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_back_to_back();
    test_flush();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
